// File: rtl/bcd_convert_arb_if.sv
// bcd_convert_arb_if -- handshake bundle for the two-requester BCD converter.
//
// Signals:
//   in0Valid/in0Data/in0Ready  requester 0 word and accept strobe
//   in1Valid/in1Data/in1Ready  requester 1 word and accept strobe
//   outValid/outReady          result handshake
//   outDigits                  BCD result, most significant digit on top
//   outCarry                   input value was >= 10^numberOfDigits
//   outId                      requester that produced the result
//   busy                       converter is not idle
// Modports:
//   slave  - the converter side
//   master - the requesters/consumer side
`timescale 1ns/1ps
interface bcd_convert_arb_if #(
    parameter int numberOfDigits = 3,
    parameter int busWidth       = 4,
    parameter int binWidth       = 10
);
    logic                               in0Valid;
    logic [binWidth-1:0]                in0Data;
    logic                               in0Ready;
    logic                               in1Valid;
    logic [binWidth-1:0]                in1Data;
    logic                               in1Ready;
    logic                               outValid;
    logic                               outReady;
    logic [busWidth*numberOfDigits-1:0] outDigits;
    logic                               outCarry;
    logic                               outId;
    logic                               busy;

    modport slave (
        input  in0Valid, in0Data, in1Valid, in1Data, outReady,
        output in0Ready, in1Ready, outValid, outDigits, outCarry, outId, busy
    );

    modport master (
        output in0Valid, in0Data, in1Valid, in1Data, outReady,
        input  in0Ready, in1Ready, outValid, outDigits, outCarry, outId, busy
    );
endinterface

// File: rtl/bcd_convert_arb.sv
// bcd_convert_arb -- binary to BCD converter (double dabble) shared between
// two requesters through a round-robin arbiter.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - bcd_convert_arb_if slave modport (request, result and busy signals)
//
// Operation: in IDLE one requester is granted (the priority pointer breaks
// ties), its word is captured on the Valid&Ready edge, then binWidth SHIFT
// cycles run the add-3/shift algorithm. The result sits in DONE until the
// consumer takes it; the pointer then moves to the other requester.
`timescale 1ns/1ps
module bcd_convert_arb #(
    parameter int numberOfDigits = 3,
    parameter int busWidth       = 4,
    parameter int binWidth       = 10
) (
    input  logic              clk,
    input  logic              rst,
    bcd_convert_arb_if.slave  bus
);
    localparam int digitBits = busWidth * numberOfDigits;
    localparam int cntWidth  = $clog2(binWidth + 1);

    // The add-3 correction only makes sense for 4-bit decimal digits.
    generate
        if (busWidth != 4) begin : gBadBusWidth
            $error("bcd_convert_arb: busWidth must be 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT                 stateReg;
    logic [digitBits-1:0]  digitsReg;
    logic [binWidth-1:0]   binReg;
    logic [cntWidth-1:0]   counterReg;
    logic                  carryReg;
    logic                  idReg;
    logic                  priorityReg;

    logic                  grant0;
    logic                  grant1;
    logic [digitBits-1:0]  adjDigits;

    // A lone requester always wins; with both asking, the pointer decides.
    assign grant0 = bus.in0Valid & (~bus.in1Valid | ~priorityReg);
    assign grant1 = bus.in1Valid & (~bus.in0Valid |  priorityReg);

    assign bus.in0Ready = (stateReg == IDLE) & grant0;
    assign bus.in1Ready = (stateReg == IDLE) & grant1;

    // Per-digit correction: any digit of 5 or more gets 3 added so that the
    // following left shift carries correctly into the next decimal digit.
    genvar gi;
    generate
        for (gi = 0; gi < numberOfDigits; gi++) begin : gAdjust
            logic [busWidth-1:0] digit;
            assign digit = digitsReg[gi*busWidth +: busWidth];
            assign adjDigits[gi*busWidth +: busWidth] =
                (digit >= busWidth'(5)) ? digit + busWidth'(3) : digit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            digitsReg   <= '0;
            binReg      <= '0;
            counterReg  <= '0;
            carryReg    <= 1'b0;
            idReg       <= 1'b0;
            priorityReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.in0Ready | bus.in1Ready) begin
                        binReg     <= bus.in1Ready ? bus.in1Data : bus.in0Data;
                        digitsReg  <= '0;
                        carryReg   <= 1'b0;
                        idReg      <= bus.in1Ready;
                        counterReg <= cntWidth'(binWidth);
                        stateReg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {top digit bit, digits, binary} shifted left as one word;
                    // the bit falling off the top digit makes the carry sticky.
                    digitsReg  <= {adjDigits[digitBits-2:0], binReg[binWidth-1]};
                    binReg     <= {binReg[binWidth-2:0], 1'b0};
                    carryReg   <= carryReg | adjDigits[digitBits-1];
                    counterReg <= counterReg - cntWidth'(1);
                    if (counterReg == cntWidth'(1)) begin
                        stateReg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.outReady) begin
                        stateReg    <= IDLE;
                        priorityReg <= ~idReg;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    // Result fields read as zero whenever no result is being offered.
    assign bus.outValid  = (stateReg == DONE);
    assign bus.outDigits = (stateReg == DONE) ? digitsReg : '0;
    assign bus.outCarry  = (stateReg == DONE) & carryReg;
    assign bus.outId     = (stateReg == DONE) & idReg;
    assign bus.busy      = (stateReg != IDLE);

endmodule

// File: tb/tb_bcd_convert_arb.sv
`timescale 1ns/1ps
module tb_bcd_convert_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_convert_arb_if #(.numberOfDigits(3), .busWidth(4), .binWidth(10)) bus();

    bcd_convert_arb #(.numberOfDigits(3), .busWidth(4), .binWidth(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int hsCount    = 0;
    int resCount   = 0;

    // Count input and output handshakes as they happen on the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            if ((bus.in0Valid && bus.in0Ready) || (bus.in1Valid && bus.in1Ready))
                hsCount <= hsCount + 1;
            if (bus.outValid && bus.outReady)
                resCount <= resCount + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic readyOf(input bit which);
        return which ? bus.in1Ready : bus.in0Ready;
    endfunction

    task automatic setValid(input bit which, input logic v);
        if (which) bus.in1Valid = v;
        else       bus.in0Valid = v;
    endtask

    // One full conversion on one requester, optionally stalling the consumer.
    task automatic doConvert(input bit which, input logic [9:0] data,
                             input logic [11:0] expD, input bit expC,
                             input int stallCycles);
        int n;
        int lat;
        bus.outReady = 1'b0;
        if (which) bus.in1Data = data;
        else       bus.in0Data = data;
        setValid(which, 1'b1);
        #1;
        n = 0;
        while (!readyOf(which) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("grant", readyOf(which), 1);
        @(posedge clk); #1;
        setValid(which, 1'b0);
        // Changing the word after acceptance must not disturb the result.
        if (which) bus.in1Data = ~data;
        else       bus.in0Data = ~data;
        checkVal("busyAfterAccept", bus.busy, 1);
        checkVal("noValidEarly", bus.outValid, 0);
        lat = 0;
        while (!bus.outValid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        checkVal("latency", lat, 10);
        checkVal("digits", bus.outDigits, expD);
        checkVal("carry", bus.outCarry, expC);
        checkVal("id", bus.outId, which);
        if (stallCycles > 0) begin
            bus.in0Valid = 1'b1;
            bus.in1Valid = 1'b1;
            #1;
            for (int i = 0; i < stallCycles; i++) begin
                checkVal("stallValid", bus.outValid, 1);
                checkVal("stallDigits", bus.outDigits, expD);
                checkVal("stallReady0", bus.in0Ready, 0);
                checkVal("stallReady1", bus.in1Ready, 0);
                checkVal("stallBusy", bus.busy, 1);
                @(posedge clk); #1;
            end
            bus.in0Valid = 1'b0;
            bus.in1Valid = 1'b0;
        end
        $display("conv req=%0d data=%0d digits=%03h carry=%0d id=%0d lat=%0d",
                 which, data, bus.outDigits, bus.outCarry, bus.outId, lat);
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.outReady = 1'b0;
        checkVal("idleAfterOut", bus.busy, 0);
        checkVal("validCleared", bus.outValid, 0);
        checkVal("digitsZeroed", bus.outDigits, 0);
    endtask

    initial begin
        int got;
        int n;
        bus.in0Valid = 1'b0;
        bus.in1Valid = 1'b0;
        bus.in0Data  = '0;
        bus.in1Data  = '0;
        bus.outReady = 1'b0;
        #1;
        checkVal("rstValid", bus.outValid, 0);
        checkVal("rstBusy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkVal("postRstValid", bus.outValid, 0);
        checkVal("postRstBusy", bus.busy, 0);
        checkVal("postRstReady0", bus.in0Ready, 0);
        checkVal("postRstReady1", bus.in1Ready, 0);
        checkVal("postRstDigits", bus.outDigits, 0);
        checkVal("postRstId", bus.outId, 0);
        @(posedge clk); #1;

        doConvert(1'b0, 10'd555,  12'h555, 1'b0, 0);
        doConvert(1'b0, 10'd0,    12'h000, 1'b0, 0);
        doConvert(1'b0, 10'd999,  12'h999, 1'b0, 0);
        doConvert(1'b0, 10'd1000, 12'h000, 1'b1, 0);
        doConvert(1'b1, 10'd1023, 12'h023, 1'b1, 0);

        // Both requesters asking continuously: grants alternate from 0.
        bus.in0Data  = 10'd123;
        bus.in1Data  = 10'd456;
        bus.in0Valid = 1'b1;
        bus.in1Valid = 1'b1;
        bus.outReady = 1'b1;
        got = 0;
        n = 0;
        while (got < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.outValid) begin
                checkVal("altId", bus.outId, got % 2);
                checkVal("altDigits", bus.outDigits, (got % 2) ? 32'h456 : 32'h123);
                $display("alt result=%0d digits=%03h id=%0d", got, bus.outDigits, bus.outId);
                got++;
            end
        end
        checkVal("altCount", got, 4);
        bus.in0Valid = 1'b0;
        bus.in1Valid = 1'b0;
        @(posedge clk); #1;
        bus.outReady = 1'b0;
        checkVal("altIdle", bus.busy, 0);

        // Consumer stalls 5 cycles; requests raised then dropped meanwhile.
        doConvert(1'b0, 10'd321, 12'h321, 1'b0, 5);
        repeat (15) @(posedge clk);
        #1;
        checkVal("noExtraValid", bus.outValid, 0);
        checkVal("noExtraBusy", bus.busy, 0);

        // Reset in the middle of SHIFT discards the conversion.
        bus.in0Data  = 10'd555;
        bus.in0Valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in0Ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in0Valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkVal("midRstValid", bus.outValid, 0);
        checkVal("midRstBusy", bus.busy, 0);
        $display("reset asserted mid-shift");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        doConvert(1'b1, 10'd42, 12'h042, 1'b0, 0);

        checkVal("handshakes", hsCount, 12);
        checkVal("results", resCount, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
